mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the single-cycle MIPS datapath. It sits directly downstream of the register file read ports and takes RD1/RD2 as its operands. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the results in architectural HI/LO registers. The HI/LO registers are also writable for MTHI/MTLO, and their contents return to the write-back mux for MFHI/MFLO.

---
 rtl/mult_div_if.sv | 16 +
 rtl/mult_div_unit.sv | 92 +++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// mult_div_if: request, HI/LO write and result signals between the datapath and mult_div_unit
interface mult_div_if #(parameter int WIDTH = 32);
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] SRC_A;
  logic [WIDTH-1:0] SRC_B;
  logic             HI_WE;
  logic             LO_WE;
  logic [WIDTH-1:0] WD;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output START, OP, SRC_A, SRC_B, HI_WE, LO_WE, WD, input BUSY, DONE, HI, LO);
  modport slave  (input START, OP, SRC_A, SRC_B, HI_WE, LO_WE, WD, output BUSY, DONE, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU over magnitudes with architectural HI/LO
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic      CLK,
  input logic      RST,
  mult_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_q, b_q, araw_q, hi_q, lo_q;
  logic               div_q, sa_q, sb_q, bz_q, busy_q, done_q;
  logic               sgn, borrow;
  logic [WIDTH-1:0]   a_abs, b_abs, rem_d, quo, rem;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sgn     = ~bus.OP[0];
    a_abs   = sgn && bus.SRC_A[WIDTH-1] ? -bus.SRC_A : bus.SRC_A;
    b_abs   = sgn && bus.SRC_B[WIDTH-1] ? -bus.SRC_B : bus.SRC_B;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    trial   = {1'b0, acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]} - {2'b00, b_q};
    // bit WIDTH of a non-borrowing trial is always 0, so folding it in is exact
    borrow  = trial[WIDTH+1] | trial[WIDTH];
    rem_d   = borrow ? {acc_q[2*WIDTH-2:WIDTH], a_q[WIDTH-1]} : trial[WIDTH-1:0];
    prod    = sa_q ^ sb_q ? -acc_q : acc_q;
    quo     = sa_q ^ sb_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.START) begin
          div_q   <= bus.OP[1];
          sa_q    <= sgn & bus.SRC_A[WIDTH-1];
          sb_q    <= sgn & bus.SRC_B[WIDTH-1];
          bz_q    <= bus.SRC_B == '0;
          a_q     <= a_abs;
          b_q     <= b_abs;
          araw_q  <= bus.SRC_A;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= CALC;
        end else begin
          if (bus.HI_WE) hi_q <= bus.WD;
          if (bus.LO_WE) lo_q <= bus.WD;
        end
        CALC: begin
          busy_q <= 1'b1;
          if (div_q) begin
            acc_q <= {rem_d, acc_q[WIDTH-2:0], ~borrow};
            a_q   <= a_q << 1;
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            b_q   <= b_q >> 1;
          end
          cnt_q   <= cnt_q == 6'(WIDTH-1) ? '0 : cnt_q + 6'd1;
          state_q <= cnt_q == 6'(WIDTH-1) ? FIX : CALC;
        end
        FIX: begin
          hi_q    <= !div_q ? prod[2*WIDTH-1:WIDTH] : bz_q ? araw_q : rem;
          lo_q    <= !div_q ? prod[WIDTH-1:0] : bz_q ? '1 : quo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit results, latency, handshake and reset
module tb_mult_div_unit;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  mult_div_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int done_at, output int busy_cnt,
                       output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.SRC_A = a;
    bus.SRC_B = b;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.HI_WE = 1'b0;
    bus.LO_WE = 1'b0;
    done_at  = 0;
    busy_cnt = 0;
    mid_hi   = 'x;
    mid_lo   = 'x;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge CLK);
      if (bus.BUSY === 1'b1) busy_cnt++;
      if (bus.DONE === 1'b1) done_at = k;
      if (k == 16) begin
        mid_hi = bus.HI;
        mid_lo = bus.LO;
      end
    end
  endtask

  task automatic test_reset;
    bus.START = 1'b0; bus.OP = 2'b00; bus.SRC_A = '0; bus.SRC_B = '0;
    bus.HI_WE = 1'b0; bus.LO_WE = 1'b0; bus.WD = '0;
    #1 RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.HI); end
    checks++; if (bus.LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.LO); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_multu;
    int d, bc; logic [31:0] mh, ml;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL multu_done_cycle: got %0d expected 33", d); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 32", bc); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done: got %b expected 0", bus.BUSY); end
    checks++; if (mh !== 32'h0 || ml !== 32'h0) begin errors++; $display("FAIL multu_hold: got %h_%h expected 00000000_00000000", mh, ml); end
    checks++; if (bus.HI !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", bus.HI); end
    checks++; if (bus.LO !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", bus.LO); end
    @(negedge CLK);
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", bus.DONE); end
  endtask

  task automatic test_mult;
    int d, bc; logic [31:0] mh, ml;
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL mult_neg_done_cycle: got %0d expected 33", d); end
    checks++; if (mh !== 32'hFFFFFFFE || ml !== 32'h00000001) begin errors++; $display("FAIL mult_hold: got %h_%h expected fffffffe_00000001", mh, ml); end
    checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", bus.HI); end
    checks++; if (bus.LO !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", bus.LO); end
    @(negedge CLK);
    do_op(2'b00, 32'h80000000, 32'h80000000, d, bc, mh, ml);
    checks++; if (bus.HI !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi: got %h expected 40000000", bus.HI); end
    checks++; if (bus.LO !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo: got %h expected 00000000", bus.LO); end
    @(negedge CLK);
  endtask

  task automatic test_div;
    int d, bc; logic [31:0] mh, ml;
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL div_done_cycle: got %0d expected 33", d); end
    checks++; if (bus.LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2_lo: got %h expected fffffffd", bus.LO); end
    checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_m7_2_hi: got %h expected ffffffff", bus.HI); end
    @(negedge CLK);
    do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, d, bc, mh, ml);
    checks++; if (bus.LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2_lo: got %h expected fffffffd", bus.LO); end
    checks++; if (bus.HI !== 32'h00000001) begin errors++; $display("FAIL div_7_m2_hi: got %h expected 00000001", bus.HI); end
    @(negedge CLK);
    do_op(2'b11, 32'd100, 32'd7, d, bc, mh, ml);
    checks++; if (bus.LO !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", bus.LO); end
    checks++; if (bus.HI !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", bus.HI); end
    @(negedge CLK);
  endtask

  task automatic test_boundaries;
    int d, bc; logic [31:0] mh, ml;
    do_op(2'b11, 32'd5, 32'd0, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL divz_done_cycle: got %0d expected 33", d); end
    checks++; if (bus.LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL divuz_lo: got %h expected ffffffff", bus.LO); end
    checks++; if (bus.HI !== 32'd5) begin errors++; $display("FAIL divuz_hi: got %h expected 00000005", bus.HI); end
    @(negedge CLK);
    do_op(2'b10, 32'hFFFFFFFB, 32'd0, d, bc, mh, ml);
    checks++; if (bus.LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_neg_lo: got %h expected ffffffff", bus.LO); end
    checks++; if (bus.HI !== 32'hFFFFFFFB) begin errors++; $display("FAIL divz_neg_hi: got %h expected fffffffb", bus.HI); end
    @(negedge CLK);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL divovf_done_cycle: got %0d expected 33", d); end
    checks++; if (bus.LO !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", bus.LO); end
    checks++; if (bus.HI !== 32'h00000000) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", bus.HI); end
    @(negedge CLK);
  endtask

  task automatic test_handshake;
    int d;
    bus.START = 1'b1; bus.OP = 2'b11; bus.SRC_A = 32'd100; bus.SRC_B = 32'd7;
    @(negedge CLK);
    bus.START = 1'b0;
    d = 0;
    for (int k = 1; k <= 40 && d == 0; k++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) d = k;
      if (k == 10) begin
        bus.START = 1'b1; bus.OP = 2'b01; bus.SRC_A = 32'h3; bus.SRC_B = 32'h3;
        bus.HI_WE = 1'b1; bus.WD = 32'h1234;
      end else begin
        bus.START = 1'b0; bus.HI_WE = 1'b0;
      end
      if (k == 12) begin
        checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL busy_mthi_ignored: got %h expected 00000000", bus.HI); end
      end
    end
    checks++; if (d !== 33) begin errors++; $display("FAIL hs_done_cycle: got %0d expected 33", d); end
    checks++; if (bus.LO !== 32'd14 || bus.HI !== 32'd2) begin errors++; $display("FAIL hs_result: got %h_%h expected 00000002_0000000e", bus.HI, bus.LO); end
    @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin errors++; $display("FAIL hs_not_queued: got busy %b done %b expected 0 0", bus.BUSY, bus.DONE); end
  endtask

  task automatic test_back_to_back;
    int d, bc; logic [31:0] mh, ml;
    do_op(2'b01, 32'd3, 32'd5, d, bc, mh, ml);
    checks++; if (bus.DONE !== 1'b1 || bus.LO !== 32'd15) begin errors++; $display("FAIL b2b_first: got done %b lo %h expected 1 0000000f", bus.DONE, bus.LO); end
    do_op(2'b01, 32'd7, 32'd6, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 33", d); end
    checks++; if (bus.LO !== 32'd42 || bus.HI !== 32'd0) begin errors++; $display("FAIL b2b_second: got %h_%h expected 00000000_0000002a", bus.HI, bus.LO); end
    @(negedge CLK);
  endtask

  task automatic test_mthi_mtlo;
    int d, bc; logic [31:0] mh, ml;
    bus.LO_WE = 1'b1; bus.WD = 32'hCAFEF00D;
    @(negedge CLK);
    bus.LO_WE = 1'b0;
    checks++; if (bus.LO !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo: got %h expected cafef00d", bus.LO); end
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 00000000", bus.HI); end
    bus.HI_WE = 1'b1; bus.LO_WE = 1'b1; bus.WD = 32'h11112222;
    @(negedge CLK);
    bus.HI_WE = 1'b0; bus.LO_WE = 1'b0;
    checks++; if (bus.HI !== 32'h11112222 || bus.LO !== 32'h11112222) begin errors++; $display("FAIL mthi_mtlo_both: got %h_%h expected 11112222_11112222", bus.HI, bus.LO); end
    bus.LO_WE = 1'b1; bus.WD = 32'hDEADBEEF;
    do_op(2'b01, 32'd2, 32'd3, d, bc, mh, ml);
    checks++; if (ml !== 32'h11112222) begin errors++; $display("FAIL start_drops_mtlo: got %h expected 11112222", ml); end
    checks++; if (bus.LO !== 32'd6) begin errors++; $display("FAIL start_drops_mtlo_result: got %h expected 00000006", bus.LO); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_op;
    int d, bc, seen; logic [31:0] mh, ml;
    bus.START = 1'b1; bus.OP = 2'b01; bus.SRC_A = 32'hFFFFFFFF; bus.SRC_B = 32'hFFFFFFFF;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (10) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin errors++; $display("FAIL async_rst_hilo: got %h_%h expected 00000000_00000000", bus.HI, bus.LO); end
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL aborted_op_activity: got %0d cycles expected 0", seen); end
    do_op(2'b01, 32'h00010000, 32'h00010000, d, bc, mh, ml);
    checks++; if (d !== 33) begin errors++; $display("FAIL post_rst_done_cycle: got %0d expected 33", d); end
    checks++; if (bus.HI !== 32'd1 || bus.LO !== 32'd0) begin errors++; $display("FAIL post_rst_result: got %h_%h expected 00000001_00000000", bus.HI, bus.LO); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_boundaries;
    test_handshake;
    test_back_to_back;
    test_mthi_mtlo;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
